// File: rtl/key_conditioner.sv
// key_conditioner: synchronises, debounces and edge-detects 16 tenkey and 3
// function-button levels into mutually exclusive single-cycle press pulses.
// Ports: clock, reset (async, active-low); key_raw/clear_raw/plus_raw/equal_raw
// raw switch levels; keys/clear/plus/equal press pulses; held = any input pressed.
module key_conditioner #(
   parameter int DIV        = 50000,
   parameter int SAMPLES    = 4,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] key_raw,
   input  logic        clear_raw,
   input  logic        plus_raw,
   input  logic        equal_raw,
   output logic [15:0] keys,
   output logic        clear,
   output logic        plus,
   output logic        equal,
   output logic        held
);

   localparam int NIN = 19;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [NIN-1:0]              raw_in;
   logic [NIN-1:0]              sync1_q, sync1_d;
   logic [NIN-1:0]              sync2_q, sync2_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic                        tick;
   logic [NIN-1:0][SAMPLES-1:0] hist_q, hist_d;
   logic [NIN-1:0]              deb_q, deb_d;
   logic [NIN-1:0]              rise;
   logic [NIN-1:0]              pulse_q, pulse_d;
   logic                        held_q, held_d;
   logic                        found;

   // Bit order doubles as the arbitration order: lowest index wins.
   // 0 = clear, 1 = equal, 2 = plus, 3+i = key i. Internally 1 = pressed.
   assign raw_in = ACTIVE_LOW ? ~{key_raw, plus_raw, equal_raw, clear_raw}
                              :  {key_raw, plus_raw, equal_raw, clear_raw};

   always_comb begin
      sync1_d = raw_in;
      sync2_d = sync1_q;

      tick  = (cnt_q == CW'(DIV - 1));
      cnt_d = tick ? '0 : cnt_q + CW'(1);

      hist_d = hist_q;
      deb_d  = deb_q;
      if (tick) begin
         for (int i = 0; i < NIN; i++) begin
            hist_d[i] = {hist_q[i][SAMPLES-2:0], sync2_q[i]};
            // A mixed history holds the previous debounced state.
            if (&hist_d[i]) begin
               deb_d[i] = 1'b1;
            end else if (~|hist_d[i]) begin
               deb_d[i] = 1'b0;
            end
         end
      end

      // deb_d only differs from deb_q on a tick, so rise is tick-qualified.
      rise = deb_d & ~deb_q;

      // Losers are simply dropped; their debounced state has already moved
      // to pressed, so they cannot fire again until released.
      pulse_d = '0;
      found   = 1'b0;
      for (int i = 0; i < NIN; i++) begin
         if (rise[i] && !found) begin
            pulse_d[i] = 1'b1;
            found      = 1'b1;
         end
      end

      held_d = |deb_d;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cnt_q   <= '0;
         hist_q  <= '0;
         deb_q   <= '0;
         pulse_q <= '0;
         held_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cnt_q   <= cnt_d;
         hist_q  <= hist_d;
         deb_q   <= deb_d;
         pulse_q <= pulse_d;
         held_q  <= held_d;
      end
   end

   assign clear = pulse_q[0];
   assign equal = pulse_q[1];
   assign plus  = pulse_q[2];
   assign keys  = pulse_q[NIN-1:3];
   assign held  = held_q;

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed scenarios plus random button activity, checked
// every cycle against a run-length debounce model, with literal expectations
// on the observed pulse log for each directed scenario.
module tb_key_conditioner;

   localparam int DIV     = 4;
   localparam int SAMPLES = 3;
   localparam int NIN     = 19;

   logic        clock;
   logic        reset;
   logic [15:0] key_raw;
   logic        clear_raw, plus_raw, equal_raw;
   logic [15:0] keys;
   logic        clear, plus, equal, held;

   key_conditioner #(.DIV(DIV), .SAMPLES(SAMPLES), .ACTIVE_LOW(1'b1)) dut (
      .clock     (clock),
      .reset     (reset),
      .key_raw   (key_raw),
      .clear_raw (clear_raw),
      .plus_raw  (plus_raw),
      .equal_raw (equal_raw),
      .keys      (keys),
      .clear     (clear),
      .plus      (plus),
      .equal     (equal),
      .held      (held)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int plog_cyc[$];
   logic [NIN-1:0] plog_val[$];

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
   endtask

   // ---------------- behavioural model ----------------
   // Debounced state is "the value of the last SAMPLES tick samples, if they
   // all agree", tracked as a run length. Pulse vector order: clear, equal,
   // plus, key0..key15 (lowest index has priority).
   logic [NIN-1:0] m_deb;
   logic [NIN-1:0] dly[$];
   int             m_runlen[NIN];
   logic           m_runval[NIN];
   int             m_n;
   logic [NIN-1:0] exp_pulse;
   logic           exp_held;

   always @(posedge clock or negedge reset) begin
      logic [NIN-1:0] s;
      logic [NIN-1:0] old;
      bit             done;
      if (!reset) begin
         m_n   = 0;
         m_deb = '0;
         for (int i = 0; i < NIN; i++) begin
            m_runval[i] = 1'b0;
            m_runlen[i] = SAMPLES;
         end
         dly.delete();
         dly.push_back('0);
         dly.push_back('0);
         exp_pulse = '0;
         exp_held  = 1'b0;
      end else begin
         s = dly.pop_front();
         dly.push_back(~{key_raw, plus_raw, equal_raw, clear_raw});
         exp_pulse = '0;
         if (m_n % DIV == DIV - 1) begin
            old = m_deb;
            for (int i = 0; i < NIN; i++) begin
               if (s[i] == m_runval[i]) m_runlen[i]++;
               else begin
                  m_runval[i] = s[i];
                  m_runlen[i] = 1;
               end
               if (m_runlen[i] >= SAMPLES) m_deb[i] = m_runval[i];
            end
            done = 0;
            for (int i = 0; i < NIN; i++) begin
               if (!done && m_deb[i] && !old[i]) begin
                  exp_pulse[i] = 1'b1;
                  done = 1;
               end
            end
         end
         exp_held = |m_deb;
         m_n++;
      end
   end

   // ---------------- per-cycle compare + pulse log ----------------
   initial begin
      logic [NIN-1:0] p;
      forever begin
         @(negedge clock);
         #1;
         cyc++;
         p = {keys, plus, equal, clear};
         check("cycle_outputs", {12'b0, p, held}, {12'b0, exp_pulse, exp_held});
         check("exclusive", ($countones(p) <= 1), 1);
         if (p != '0) begin
            plog_cyc.push_back(cyc);
            plog_val.push_back(p);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic drive(input logic [NIN-1:0] pressed);
      {key_raw, plus_raw, equal_raw, clear_raw} = ~pressed;
   endtask

   task automatic check_window(input string nm, input int mark, input logic [NIN-1:0] v,
                               input int n_exp);
      check({nm, "_count"}, plog_val.size() - mark, n_exp);
      for (int k = mark; k < plog_val.size(); k++)
         check({nm, "_value"}, plog_val[k], v);
   endtask

   function automatic logic [NIN-1:0] key_bit(input int k);
      logic [NIN-1:0] v;
      v = '0;
      v[3 + k] = 1'b1;
      return v;
   endfunction

   localparam logic [NIN-1:0] P_CLEAR = 19'd1;
   localparam logic [NIN-1:0] P_EQUAL = 19'd2;
   localparam logic [NIN-1:0] P_PLUS  = 19'd4;

   initial begin
      int             mark, t0, lat;
      logic [NIN-1:0] v;

      reset = 1'b1;
      drive('0);
      #3 reset = 1'b0;
      wait_cyc(3);
      check("reset_outputs", {keys, clear, plus, equal, held}, 0);
      reset = 1'b1;
      wait_cyc(10);

      // 1: clean press of key 5
      mark = plog_val.size();
      t0 = cyc + 1;
      drive(key_bit(5));
      wait_cyc(30);
      check("s1_held_during", held, 1);
      wait_cyc(30);
      drive('0);
      wait_cyc(30);
      check("s1_held_after", held, 0);
      check_window("s1", mark, {16'h0020, 3'b000}, 1);
      if (plog_val.size() > mark) begin
         lat = plog_cyc[mark] - t0;
         check("s1_latency_in_11_to_15", (lat >= 11 && lat <= 15), 1);
      end

      // 2: key 9 bounces with 3-cycle phases, then a solid hold
      mark = plog_val.size();
      for (int s = 0; s < 10; s++) begin
         drive((s % 2 == 0) ? key_bit(9) : '0);
         wait_cyc(3);
      end
      t0 = cyc + 1;
      drive(key_bit(9));
      wait_cyc(40);
      drive('0);
      wait_cyc(30);
      check_window("s2", mark, {16'h0200, 3'b000}, 1);
      if (plog_val.size() > mark)
         check("s2_after_hold", (plog_cyc[mark] >= t0 + 11), 1);

      // 3: glitch while pressed, then release and re-press
      mark = plog_val.size();
      drive(key_bit(2));
      wait_cyc(30);
      drive('0);
      wait_cyc(2);
      drive(key_bit(2));
      wait_cyc(30);
      check("s3_no_glitch_pulse", plog_val.size() - mark, 1);
      drive('0);
      wait_cyc(20);
      drive(key_bit(2));
      wait_cyc(30);
      drive('0);
      wait_cyc(30);
      check_window("s3", mark, {16'h0004, 3'b000}, 2);

      // 4: key 3 and plus together -> plus only
      mark = plog_val.size();
      drive(key_bit(3) | P_PLUS);
      wait_cyc(40);
      drive('0);
      wait_cyc(30);
      check_window("s4", mark, P_PLUS, 1);

      // 5: clear, equal, key 0 together -> clear; then equal alone
      mark = plog_val.size();
      drive(P_CLEAR | P_EQUAL | key_bit(0));
      wait_cyc(40);
      drive('0);
      wait_cyc(30);
      check_window("s5a", mark, P_CLEAR, 1);
      mark = plog_val.size();
      drive(P_EQUAL);
      wait_cyc(40);
      drive('0);
      wait_cyc(30);
      check_window("s5b", mark, P_EQUAL, 1);

      // 6: reset in the middle of a key 7 hold
      drive(key_bit(7));
      wait_cyc(40);
      check("s6_held_before_reset", held, 1);
      reset = 1'b0;
      #2;
      check("s6_reset_outputs", {keys, clear, plus, equal, held}, 0);
      wait_cyc(5);
      reset = 1'b1;
      mark = plog_val.size();
      wait_cyc(40);
      drive('0);
      wait_cyc(30);
      check_window("s6", mark, {16'h0080, 3'b000}, 1);

      // random activity, including one reset, checked by the model each cycle
      for (int r = 0; r < 160; r++) begin
         v = '0;
         for (int i = 0; i < NIN; i++)
            if ($urandom_range(0, 5) == 0) v[i] = 1'b1;
         drive(v);
         wait_cyc($urandom_range(1, 24));
         if (r == 80) begin
            reset = 1'b0;
            wait_cyc(3);
            reset = 1'b1;
         end
      end
      drive('0);
      wait_cyc(30);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
